// File: rtl/mem_store_pkg.sv
// rtl/mem_store_pkg.sv - shared encodings for the data-memory store controller
package mem_store_pkg;

  // Store access size as presented by the MEM stage
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Completion status reported alongside done
  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_SIZE     = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_e;

  // Controller states; outputs are decoded directly from these
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERR   = 2'b11
  } state_e;

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - size/offset to little-endian byte lanes and legality flags
module store_align
  import mem_store_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misalign,
  output logic        illegal
);

  // Replicate the right-justified data across all lanes so the selected lane
  // always carries it; the byte enables pick which lanes memory writes.
  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << off;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be       = off[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{data[15:0]}};
        misalign = off[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        wdata    = data;
        misalign = |off;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_store_ctrl.sv
// rtl/mem_store_ctrl.sv - store request FSM driving a req/ack data-memory write port
module mem_store_ctrl
  import mem_store_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nReset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  err_e          code_q, code_d;
  logic          load;

  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic          al_mis;
  logic          al_ill;

  store_align u_align (
    .size     (size_e'(req_size)),
    .off      (req_addr[1:0]),
    .data     (req_data),
    .be       (al_be),
    .wdata    (al_wdata),
    .misalign (al_mis),
    .illegal  (al_ill)
  );

  // Next-state logic: accept/classify in IDLE, wait for ack or timeout in ISSUE
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    code_d  = code_q;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (al_ill) begin
            state_d = ST_ERR;
            code_d  = ERR_SIZE;
          end else if (al_mis) begin
            state_d = ST_ERR;
            code_d  = ERR_MISALIGN;
          end else begin
            state_d = ST_ISSUE;
            code_d  = ERR_NONE;
            cnt_d   = '0;
            load    = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt == CNT_LAST) begin
          state_d = ST_ERR;
          code_d  = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, status and memory-port registers; the port is loaded only on a legal accept
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      code_q    <= ERR_NONE;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      code_q <= code_d;
      if (load) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= al_wdata;
        mem_be    <= al_be;
      end
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign mem_req   = (state == ST_ISSUE);
  assign done      = (state == ST_DONE) || (state == ST_ERR);
  assign err       = (state == ST_ERR);
  assign err_code  = code_q;

endmodule
